// File: rtl/tmds_serial_mc.sv
// tmds_serial_mc -- multi-lane parallel-to-serial transmitter for the TMDS path.
//
// Takes one W-bit word per lane from the TMDS encoders and shifts it out
// LSB first at R bits per clock (R=2 for DDR, 1 for SDR). The output feeds
// the external DDR output primitives. Bit l*R+0 of each lane slice is sent
// first and drives the primitive's rising-edge data input.
//
// Parameters:
//   W         word width per lane (must be even when DDR=1)
//   LANES     number of serial lanes
//   DDR       1 = two bits per clock, 0 = one bit per clock
//   INV_MASK  per-lane p/n swap
//   IDLE_WORD word sent on underrun and after align
//
// Ports:
//   clk          serial-rate clock (W/R clocks per word)
//   rst          asynchronous active-high reset
//   d            parallel words, lane l at d[l*W +: W]
//   d_valid      d holds a new word set
//   d_ready      d is sampled at this edge (word boundary, no align)
//   align        single-cycle soft phase restart
//   underrun_clr clears the sticky underrun flag
//   underrun     set when a word was needed and d_valid was low
//   q_p / q_n    positive / negative leg bits, lane l at [l*R +: R]
//
// Optional build macro TMDS_SERIAL_PRBS_EN adds input prbs_mode. This
// replaces the lane data with a PRBS7 (x^7+x^6+1) test stream that is
// common to all lanes.
module tmds_serial_mc #(
  parameter int               W         = 10,
  parameter int               LANES     = 3,
  parameter int               DDR       = 1,
  parameter logic [LANES-1:0] INV_MASK  = '0,
  parameter logic [W-1:0]     IDLE_WORD = 10'h354
) (
  input  logic                                 clk,
  input  logic                                 rst,
  input  logic [LANES*W-1:0]                   d,
  input  logic                                 d_valid,
  output logic                                 d_ready,
  input  logic                                 align,
  input  logic                                 underrun_clr,
  output logic                                 underrun,
`ifdef TMDS_SERIAL_PRBS_EN
  input  logic                                 prbs_mode,
`endif
  output logic [LANES*((DDR != 0) ? 2 : 1)-1:0] q_p,
  output logic [LANES*((DDR != 0) ? 2 : 1)-1:0] q_n
);

  localparam int R  = (DDR != 0) ? 2 : 1;
  localparam int S  = W / R;
  localparam int PW = (S > 1) ? $clog2(S) : 1;
  localparam logic [PW-1:0] PH_LAST = PW'(S - 1);

  logic [PW-1:0] ph;
  logic [W-1:0]  sh_p0 [LANES];
  logic          boundary;
  logic          prbs_sel;
  logic [R-1:0]  prbs_bits;
  logic          underrun_set;

  assign boundary     = (ph == PH_LAST);
  // align steals the boundary: the word on d is left for S edges later.
  assign d_ready      = boundary && !align && !prbs_sel;
  assign underrun_set = boundary && !align && !prbs_sel && !d_valid;

`ifdef TMDS_SERIAL_PRBS_EN
  logic [6:0] lfsr;
  logic [6:0] lfsr_nxt;
  logic       prbs_act;

  // A mode change only lands on a word boundary; in between the latched mode rules.
  assign prbs_sel = boundary ? prbs_mode : prbs_act;

  // Advance the generator R steps per clock; the first new bit is sent first.
  always_comb begin
    lfsr_nxt  = lfsr;
    prbs_bits = '0;
    for (int i = 0; i < R; i++) begin
      prbs_bits[i] = lfsr_nxt[6] ^ lfsr_nxt[5];
      lfsr_nxt     = {lfsr_nxt[5:0], prbs_bits[i]};
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      lfsr     <= 7'h7F;
      prbs_act <= 1'b0;
    end else begin
      if (boundary && !align) prbs_act <= prbs_mode;
      if (prbs_sel && !align) lfsr <= lfsr_nxt;
    end
  end
`else
  assign prbs_sel  = 1'b0;
  assign prbs_bits = '0;
`endif

  // Stage p0: shift registers and phase counter; stage p1: registered q legs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ph       <= PH_LAST;
      underrun <= 1'b0;
      q_p      <= '0;
      q_n      <= '1;
      for (int l = 0; l < LANES; l++) sh_p0[l] <= IDLE_WORD;
    end else begin
      for (int l = 0; l < LANES; l++) begin
        q_p[l*R +: R] <= sh_p0[l][R-1:0] ^ {R{INV_MASK[l]}};
        q_n[l*R +: R] <= ~(sh_p0[l][R-1:0] ^ {R{INV_MASK[l]}});
        if (align)          sh_p0[l] <= IDLE_WORD;
        else if (prbs_sel)  sh_p0[l] <= W'(prbs_bits);
        else if (!boundary) sh_p0[l] <= sh_p0[l] >> R;
        else if (d_valid)   sh_p0[l] <= d[l*W +: W];
        else                sh_p0[l] <= IDLE_WORD;
      end
      ph <= (align || boundary) ? '0 : ph + 1'b1;
      // A new underrun wins over a simultaneous clear.
      if (!prbs_sel) underrun <= underrun_set | (underrun & ~underrun_clr);
    end
  end

endmodule

// File: tb/tb_tmds_serial_mc.sv
// Testbench for tmds_serial_mc: W=10, LANES=3, DDR=1, INV_MASK=3'b010.
// q_p slice layout per vector: {lane2[1:0], lane1[1:0], lane0[1:0]}.
module tb_tmds_serial_mc;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [29:0] d = '0;
  logic        d_valid = 1'b0;
  logic        d_ready;
  logic        align = 1'b0;
  logic        underrun_clr = 1'b0;
  logic        underrun;
  logic [5:0]  q_p;
  logic [5:0]  q_n;
`ifdef TMDS_SERIAL_PRBS_EN
  logic        prbs_mode = 1'b0;
`endif

  int errors = 0;
  int checks = 0;

  tmds_serial_mc #(
    .W(10), .LANES(3), .DDR(1), .INV_MASK(3'b010), .IDLE_WORD(10'h354)
  ) dut (
    .clk(clk), .rst(rst), .d(d), .d_valid(d_valid), .d_ready(d_ready),
    .align(align), .underrun_clr(underrun_clr), .underrun(underrun),
`ifdef TMDS_SERIAL_PRBS_EN
    .prbs_mode(prbs_mode),
`endif
    .q_p(q_p), .q_n(q_n)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        dv;
    logic        al;
    logic        clr;
    logic [29:0] dd;
    logic        rdy;
    logic [5:0]  qp;
    logic        ur;
  } vec_t;

  vec_t vt[64];
  int   nv = 0;

  localparam logic [29:0] SA = {10'h3FF, 10'h155, 10'h2AA};
  localparam logic [29:0] SB = {10'h000, 10'h3FF, 10'h0F0};
  localparam logic [29:0] SC = {10'h2AA, 10'h000, 10'h30F};

  task automatic add(input int dv, input int al, input int clr, input logic [29:0] dd,
                     input int rdy, input logic [5:0] qp, input int ur);
    vt[nv].dv  = (dv != 0);
    vt[nv].al  = (al != 0);
    vt[nv].clr = (clr != 0);
    vt[nv].dd  = dd;
    vt[nv].rdy = (rdy != 0);
    vt[nv].qp  = qp;
    vt[nv].ur  = (ur != 0);
    nv++;
  endtask

  task automatic chk(input string nm, input int t, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s t=%0d got=%0h want=%0h", nm, t, act, exp);
    end
  endtask

  logic [5:0] nq;

`ifdef TMDS_SERIAL_PRBS_EN
  logic [6:0] s;
  logic [1:0] pr;
  logic [5:0] pq;
`endif

  initial begin
    // Edge-by-edge table; the index+1 is the edge number after reset release.
    add(1,0,0,SA,1,6'h0C,0);                                  // 1: accept A, idle pair 00 out
    for (int i = 0; i < 4; i++) add(1,0,0,SB,0,6'h3A,0);      // 2-5: A pairs
    add(1,0,0,SB,1,6'h3A,0);                                  // 6: accept B
    add(1,0,0,SC,0,6'h00,0); add(1,0,0,SC,0,6'h00,0);         // 7-8: 0F0 pairs 00,00
    add(1,0,0,SC,0,6'h03,0); add(1,0,0,SC,0,6'h03,0);         // 9-10: 11,11
    add(1,0,0,SC,1,6'h00,0);                                  // 11: accept C, last 00
    add(1,0,0,SC,0,6'h2F,0); add(1,0,0,SC,0,6'h2F,0);         // 12-13: 30F pairs 11,11
    add(1,0,0,SC,0,6'h2C,0); add(1,0,0,SC,0,6'h2C,0);         // 14-15: 00,00
    add(0,0,0,SC,1,6'h2F,1);                                  // 16: underrun
    add(0,0,0,SC,0,6'h0C,1);                                  // 17: idle stream
    add(0,0,1,SC,0,6'h19,0);                                  // 18: clear
    add(0,0,0,SC,0,6'h19,0); add(0,0,0,SC,0,6'h19,0);         // 19-20
    add(0,0,1,SC,1,6'h33,1);                                  // 21: clear + set -> set
    add(1,0,1,SA,0,6'h0C,0);                                  // 22: clear
    add(1,0,0,SA,0,6'h19,0);                                  // 23
    add(1,1,0,SA,0,6'h19,0);                                  // 24: align at ph=2
    add(0,0,0,SA,0,6'h0C,0);                                  // 25: idle restarts
    for (int i = 0; i < 3; i++) add(0,0,0,SA,0,6'h19,0);      // 26-28
    add(0,1,0,SA,0,6'h33,0);                                  // 29: align at boundary
    add(1,0,0,SA,0,6'h0C,0);                                  // 30
    for (int i = 0; i < 3; i++) add(1,0,0,SA,0,6'h19,0);      // 31-33
    add(1,0,0,SA,1,6'h33,0);                                  // 34: accept A
    for (int i = 0; i < 4; i++) add(1,0,0,SA,0,6'h3A,0);      // 35-38
    add(1,0,0,SA,1,6'h3A,0);                                  // 39: accept A again

    // Reset state
    #12;
    chk("rst_q_p", 0, 32'(q_p), 32'h00);
    chk("rst_q_n", 0, 32'(q_n), 32'h3F);
    chk("rst_underrun", 0, 32'(underrun), 32'h0);
    chk("rst_d_ready", 0, 32'(d_ready), 32'h1);
    @(posedge clk);
    #2 rst = 1'b0;

    for (int i = 0; i < nv; i++) begin
      @(negedge clk);
      d            = vt[i].dd;
      d_valid      = vt[i].dv;
      align        = vt[i].al;
      underrun_clr = vt[i].clr;
      #1;
      chk("d_ready", i + 1, 32'(d_ready), 32'(vt[i].rdy));
      @(posedge clk);
      #1;
      nq = ~vt[i].qp;
      chk("q_p", i + 1, 32'(q_p), 32'(vt[i].qp));
      chk("q_n", i + 1, 32'(q_n), 32'(nq));
      chk("underrun", i + 1, 32'(underrun), 32'(vt[i].ur));
    end

    // Asynchronous reset in the middle of word A
    @(negedge clk);
    d = SA; d_valid = 1'b1; align = 1'b0; underrun_clr = 1'b0;
    @(posedge clk);
    #1 chk("pre_rst_q_p", 40, 32'(q_p), 32'h3A);
    #2 rst = 1'b1;
    #1;
    chk("mid_rst_q_p", 40, 32'(q_p), 32'h00);
    chk("mid_rst_q_n", 40, 32'(q_n), 32'h3F);
    chk("mid_rst_underrun", 40, 32'(underrun), 32'h0);
    chk("mid_rst_d_ready", 40, 32'(d_ready), 32'h1);
    @(posedge clk);
    #2 rst = 1'b0;
    @(posedge clk);
    #1;
    chk("post_rst_q_p", 41, 32'(q_p), 32'h0C);
    chk("post_rst_q_n", 41, 32'(q_n), 32'h33);
    @(posedge clk);
    #1 chk("post_rst_word", 42, 32'(q_p), 32'h3A);

`ifdef TMDS_SERIAL_PRBS_EN
    // PRBS7 from seed 7F: first edge loads, bits appear from the second edge on.
    @(negedge clk);
    rst = 1'b1; prbs_mode = 1'b1; d_valid = 1'b0;
    @(posedge clk);
    #2 rst = 1'b0;
    @(negedge clk);
    #1 chk("prbs_d_ready", 100, 32'(d_ready), 32'h0);
    @(posedge clk);
    s = 7'h7F;
    for (int k = 0; k < 7; k++) begin
      @(negedge clk);
      #1 chk("prbs_d_ready", 101 + k, 32'(d_ready), 32'h0);
      pr[0] = s[6] ^ s[5]; s = {s[5:0], pr[0]};
      pr[1] = s[6] ^ s[5]; s = {s[5:0], pr[1]};
      pq = {pr, ~pr, pr};
      @(posedge clk);
      #1;
      nq = ~pq;
      chk("prbs_q_p", 101 + k, 32'(q_p), 32'(pq));
      chk("prbs_q_n", 101 + k, 32'(q_n), 32'(nq));
      chk("prbs_underrun", 101 + k, 32'(underrun), 32'h0);
    end
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
